// File: rtl/brush_pixel_writer_pkg.sv
// Shared definitions for the pixel RAM writer and the pooling reader:
// FSM state encoding, default geometry and width helper functions.
package brush_pixel_writer_pkg;

    localparam int DEFAULT_SIDE  = 112;
    localparam int DEFAULT_BRUSH = 4;

    typedef enum logic [2:0] {
        ST_RESET      = 3'd0,
        ST_IDLE       = 3'd1,
        ST_CLEAR      = 3'd2,
        ST_CLEAR_DONE = 3'd3,
        ST_PAINT      = 3'd4
    } state_t;

    // Width of an x or y coordinate for a square matrix of the given side.
    function automatic int coord_bits(input int side);
        return $clog2(side);
    endfunction

    // Width of a linear pixel address for a square matrix of the given side.
    function automatic int addr_bits(input int side);
        return $clog2(side * side);
    endfunction

    // Width of a counter holding 0..n-1; never narrower than one bit.
    function automatic int counter_bits(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/brush_pixel_writer_if.sv
// Point handshake from the coordinate front end plus the pixel RAM write port.
// The slave side is the writer; the master side is the front end / RAM.
interface brush_pixel_writer_if
    import brush_pixel_writer_pkg::*;
#(
    parameter int coord_width      = coord_bits(DEFAULT_SIDE),
    parameter int pixel_addr_width = addr_bits(DEFAULT_SIDE)
) ();

    logic                        point_valid;
    logic                        point_ready;
    logic [coord_width-1:0]      point_x;
    logic [coord_width-1:0]      point_y;
    logic [pixel_addr_width-1:0] pixel_addr;
    logic                        pixel_data;
    logic                        pixel_we;

    modport master (
        output point_valid, point_x, point_y,
        input  point_ready, pixel_addr, pixel_data, pixel_we
    );

    modport slave (
        input  point_valid, point_x, point_y,
        output point_ready, pixel_addr, pixel_data, pixel_we
    );

endinterface

// File: rtl/brush_pixel_writer_counter.sv
// Wrapping up-counter: counts 0..MAX_VALUE-1 on each enabled cycle,
// then returns to 0, so it is ready for the next pass without a clear.
module brush_pixel_writer_counter
    import brush_pixel_writer_pkg::*;
#(
    parameter int MAX_VALUE = 4,
    parameter int WIDTH     = counter_bits(MAX_VALUE)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    output logic [WIDTH-1:0] count
);

    localparam logic [WIDTH-1:0] LAST = WIDTH'(MAX_VALUE - 1);

    // Advance on enable and wrap at the last value.
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (en) begin
            count <= (count == LAST) ? '0 : count + 1'b1;
        end
    end

endmodule

// File: rtl/brush_pixel_writer.sv
// Writer side of the 1-bit pixel RAM: paints a BxB brush of 1s around each
// accepted point, one pixel per cycle, and bulk-clears the RAM on request.
module brush_pixel_writer
    import brush_pixel_writer_pkg::*;
#(
    parameter int matrix_side_length = DEFAULT_SIDE,
    parameter int brush_size         = DEFAULT_BRUSH,
    parameter int coord_width        = coord_bits(matrix_side_length),
    parameter int pixel_addr_width   = addr_bits(matrix_side_length)
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       en,
    input  logic                       clear,
    brush_pixel_writer_if.slave        bus,
    output logic                       busy,
    output logic                       clear_done
);

    localparam int CLEAR_W = counter_bits(matrix_side_length * matrix_side_length);
    localparam int BRUSH_W = counter_bits(brush_size);

    localparam logic [CLEAR_W-1:0]        CLEAR_LAST = CLEAR_W'(matrix_side_length * matrix_side_length - 1);
    localparam logic [BRUSH_W-1:0]        BRUSH_LAST = BRUSH_W'(brush_size - 1);
    localparam logic signed [coord_width:0] HALF     = (coord_width + 1)'(brush_size / 2);

    state_t state;
    state_t next_state;

    logic signed [coord_width:0] tx;
    logic signed [coord_width:0] ty;

    logic [CLEAR_W-1:0] clear_cnt;
    logic [BRUSH_W-1:0] col_cnt;
    logic [BRUSH_W-1:0] row_cnt;

    logic accept;
    logic clear_step;
    logic col_step;
    logic row_step;

    int   col_pos;
    int   row_pos;
    int   addr_full;
    logic in_range;

    assign accept     = (state == ST_IDLE) && en && !clear && bus.point_valid;
    assign clear_step = (state == ST_CLEAR) && en;
    assign col_step   = (state == ST_PAINT) && en;
    assign row_step   = col_step && (col_cnt == BRUSH_LAST);

    brush_pixel_writer_counter #(
        .MAX_VALUE (matrix_side_length * matrix_side_length),
        .WIDTH     (CLEAR_W)
    ) u_clear_counter (
        .clk   (clk),
        .reset (reset),
        .en    (clear_step),
        .count (clear_cnt)
    );

    brush_pixel_writer_counter #(
        .MAX_VALUE (brush_size),
        .WIDTH     (BRUSH_W)
    ) u_col_counter (
        .clk   (clk),
        .reset (reset),
        .en    (col_step),
        .count (col_cnt)
    );

    brush_pixel_writer_counter #(
        .MAX_VALUE (brush_size),
        .WIDTH     (BRUSH_W)
    ) u_row_counter (
        .clk   (clk),
        .reset (reset),
        .en    (row_step),
        .count (row_cnt)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_RESET;
        end else begin
            state <= next_state;
        end
    end

    // Latch the brush top-left corner in the handshake cycle; may be negative.
    always_ff @(posedge clk) begin
        if (reset) begin
            tx <= '0;
            ty <= '0;
        end else if (accept) begin
            tx <= $signed({1'b0, bus.point_x}) - HALF;
            ty <= $signed({1'b0, bus.point_y}) - HALF;
        end
    end

    // Current brush pixel position, widened so out-of-range points cannot wrap into range.
    always_comb begin
        col_pos   = int'(tx) + int'(col_cnt);
        row_pos   = int'(ty) + int'(row_cnt);
        in_range  = (col_pos >= 0) && (col_pos < matrix_side_length) &&
                    (row_pos >= 0) && (row_pos < matrix_side_length);
        addr_full = row_pos * matrix_side_length + col_pos;
    end

    // Next-state logic and registered-state-driven outputs.
    always_comb begin
        next_state      = state;
        bus.point_ready = 1'b0;
        bus.pixel_we    = 1'b0;
        bus.pixel_data  = 1'b0;
        bus.pixel_addr  = '0;
        busy            = 1'b0;
        clear_done      = 1'b0;
        case (state)
            ST_RESET: begin
                if (en) begin
                    next_state = ST_IDLE;
                end
            end
            ST_IDLE: begin
                bus.point_ready = en && !clear;
                if (en && clear) begin
                    next_state = ST_CLEAR;
                end else if (en && bus.point_valid) begin
                    next_state = ST_PAINT;
                end
            end
            ST_CLEAR: begin
                busy           = 1'b1;
                bus.pixel_we   = en;
                bus.pixel_addr = pixel_addr_width'(clear_cnt);
                if (en && (clear_cnt == CLEAR_LAST)) begin
                    next_state = ST_CLEAR_DONE;
                end
            end
            ST_CLEAR_DONE: begin
                clear_done = en;
                if (en) begin
                    next_state = ST_IDLE;
                end
            end
            ST_PAINT: begin
                busy           = 1'b1;
                bus.pixel_data = 1'b1;
                bus.pixel_we   = en && in_range;
                bus.pixel_addr = pixel_addr_width'(addr_full);
                if (en && (col_cnt == BRUSH_LAST) && (row_cnt == BRUSH_LAST)) begin
                    next_state = ST_IDLE;
                end
            end
            default: begin
                next_state = ST_RESET;
            end
        endcase
    end

endmodule

// File: tb/tb_brush_pixel_writer.sv
// Self-checking bench for brush_pixel_writer: table-driven brush points,
// a write scoreboard, and sequences for clear priority, en gaps and reset.
module tb_brush_pixel_writer;
    import brush_pixel_writer_pkg::*;

    localparam int SIDE = 112;
    localparam int B    = 4;
    localparam int CW   = 7;
    localparam int AW   = 14;

    logic clk = 1'b0;
    logic reset;
    logic en;
    logic clear;
    logic busy;
    logic clear_done;

    brush_pixel_writer_if #(.coord_width(CW), .pixel_addr_width(AW)) bus ();

    brush_pixel_writer #(
        .matrix_side_length (SIDE),
        .brush_size         (B),
        .coord_width        (CW),
        .pixel_addr_width   (AW)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .en         (en),
        .clear      (clear),
        .bus        (bus),
        .busy       (busy),
        .clear_done (clear_done)
    );

    // Free-running 100 MHz clock.
    always #5 clk = ~clk;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic          data;
    } wr_t;

    typedef struct {
        int x;
        int y;
        int writes;
        int first;
        int last;
    } vec_t;

    wr_t  exp_q[$];
    vec_t vecs[6];

    int checks      = 0;
    int errors      = 0;
    int cycle_no    = 0;
    int write_count = 0;
    int done_count  = 0;
    int done_cycle  = 0;
    int hs_cycle    = 0;
    int first_addr  = 0;
    int last_addr   = 0;
    int t0          = 0;

    logic          s_ready;
    logic          s_we;
    logic          s_busy;
    logic          s_done;
    logic          s_data;
    logic [AW-1:0] s_addr;

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Model of the brush footprint: column fastest, only in-range pixels written.
    task automatic push_brush(input int x, input int y);
        for (int r = 0; r < B; r++) begin
            for (int c = 0; c < B; c++) begin
                int col;
                int row;
                col = x - B / 2 + c;
                row = y - B / 2 + r;
                if (col >= 0 && col < SIDE && row >= 0 && row < SIDE) begin
                    exp_q.push_back('{addr: AW'(row * SIDE + col), data: 1'b1});
                end
            end
        end
    endtask

    task automatic push_clear();
        for (int a = 0; a < SIDE * SIDE; a++) begin
            exp_q.push_back('{addr: AW'(a), data: 1'b0});
        end
    endtask

    // One clock cycle: sample outputs mid-cycle, score writes, end just after the next edge.
    task automatic tick();
        @(negedge clk);
        cycle_no++;
        s_ready = bus.point_ready;
        s_we    = bus.pixel_we;
        s_busy  = busy;
        s_done  = clear_done;
        s_data  = bus.pixel_data;
        s_addr  = bus.pixel_addr;
        if (s_done === 1'b1) begin
            done_count++;
            done_cycle = cycle_no;
        end
        if (s_we === 1'b1) begin
            write_count++;
            if (write_count == 1) first_addr = int'(s_addr);
            last_addr = int'(s_addr);
            checkOutput("sb_pending", int'(exp_q.size() > 0), 1);
            if (exp_q.size() > 0) begin
                wr_t e;
                e = exp_q.pop_front();
                checkOutput("write_addr", int'(s_addr), int'(e.addr));
                checkOutput("write_data", int'(s_data), int'(e.data));
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input int x, input int y);
        bus.point_x     = CW'(x);
        bus.point_y     = CW'(y);
        bus.point_valid = 1'b1;
        push_brush(x, y);
    endtask

    task automatic wait_handshake(input int bound);
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < bound && !seen; k++) begin
            tick();
            if (s_ready === 1'b1) begin
                seen     = 1'b1;
                hs_cycle = cycle_no;
            end
        end
        bus.point_valid = 1'b0;
        checkOutput("handshake", int'(seen), 1);
    endtask

    task automatic measure_paint(input int expected_cycles);
        bit seen;
        int n;
        int nb;
        seen = 1'b0;
        n    = 0;
        nb   = 0;
        for (int k = 0; k < 64 && !seen; k++) begin
            tick();
            if (s_ready === 1'b1) begin
                seen = 1'b1;
            end else begin
                n++;
                if (s_busy === 1'b1) nb++;
            end
        end
        checkOutput("ready_returns", int'(seen), 1);
        checkOutput("paint_cycles", n, expected_cycles);
        checkOutput("paint_busy_cycles", nb, expected_cycles);
    endtask

    task automatic run_point(input vec_t v, input string tag);
        write_count = 0;
        applyStimulus(v.x, v.y);
        wait_handshake(50);
        measure_paint(B * B);
        checkOutput({tag, "_writes"}, write_count, v.writes);
        if (v.writes > 0) begin
            checkOutput({tag, "_first_addr"}, first_addr, v.first);
            checkOutput({tag, "_last_addr"}, last_addr, v.last);
        end
    endtask

    // Watchdog so the bench always terminates.
    initial begin
        #5ms;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vecs[0] = '{x: 10,  y: 20,  writes: 16, first: 2024,  last: 2363};
        vecs[1] = '{x: 0,   y: 0,   writes: 4,  first: 0,     last: 113};
        vecs[2] = '{x: 111, y: 111, writes: 9,  first: 12317, last: 12543};
        vecs[3] = '{x: 60,  y: 60,  writes: 16, first: 6554,  last: 6893};
        vecs[4] = '{x: 127, y: 127, writes: 0,  first: 0,     last: 0};
        vecs[5] = '{x: 1,   y: 111, writes: 9,  first: 12208, last: 12434};

        reset           = 1'b1;
        en              = 1'b1;
        clear           = 1'b0;
        bus.point_valid = 1'b0;
        bus.point_x     = '0;
        bus.point_y     = '0;

        // Reset state.
        tick();
        tick();
        checkOutput("rst_ready", int'(s_ready), 0);
        checkOutput("rst_we", int'(s_we), 0);
        checkOutput("rst_busy", int'(s_busy), 0);
        checkOutput("rst_done", int'(s_done), 0);
        checkOutput("rst_addr", int'(s_addr), 0);
        reset = 1'b0;
        tick();
        checkOutput("reset_state_ready", int'(s_ready), 0);
        tick();
        checkOutput("idle_ready", int'(s_ready), 1);

        // Table-driven brush points.
        for (int i = 0; i < 6; i++) begin
            run_point(vecs[i], $sformatf("vec%0d", i));
        end

        // Clear and point together: clear wins, point stays pending.
        $display("[TB] clear with pending point");
        write_count = 0;
        done_count  = 0;
        clear       = 1'b1;
        push_clear();
        applyStimulus(10, 20);
        tick();
        t0 = cycle_no;
        checkOutput("clear_priority_ready", int'(s_ready), 0);
        clear = 1'b0;
        wait_handshake(13000);
        checkOutput("clear_writes", write_count, SIDE * SIDE);
        checkOutput("clear_done_pulses", done_count, 1);
        checkOutput("clear_done_latency", done_cycle - t0, SIDE * SIDE + 1);
        checkOutput("pending_point_latency", hs_cycle - t0, SIDE * SIDE + 2);
        write_count = 0;
        measure_paint(B * B);
        checkOutput("pending_writes", write_count, 16);
        checkOutput("pending_first_addr", first_addr, 2024);
        checkOutput("pending_last_addr", last_addr, 2363);

        // en dropped for 5 cycles after 7 writes.
        $display("[TB] en gap during paint");
        write_count = 0;
        applyStimulus(60, 60);
        wait_handshake(50);
        repeat (7) tick();
        checkOutput("gap_writes_before", write_count, 7);
        en = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
            checkOutput("gap_we", int'(s_we), 0);
            checkOutput("gap_busy", int'(s_busy), 1);
            checkOutput("gap_ready", int'(s_ready), 0);
        end
        checkOutput("gap_writes_held", write_count, 7);
        en = 1'b1;
        measure_paint(9);
        checkOutput("gap_writes_total", write_count, 16);
        checkOutput("gap_last_addr", last_addr, 6893);

        // Reset in the middle of a clear.
        $display("[TB] reset during clear");
        write_count = 0;
        clear       = 1'b1;
        push_clear();
        tick();
        clear = 1'b0;
        for (int k = 0; k < 200 && write_count < 99; k++) tick();
        checkOutput("pre_reset_writes", write_count, 99);
        reset = 1'b1;
        tick();
        checkOutput("writes_at_reset", write_count, 100);
        tick();
        checkOutput("midrst_we", int'(s_we), 0);
        checkOutput("midrst_busy", int'(s_busy), 0);
        checkOutput("midrst_ready", int'(s_ready), 0);
        checkOutput("midrst_done", int'(s_done), 0);
        checkOutput("midrst_addr", int'(s_addr), 0);
        checkOutput("midrst_write_count", write_count, 100);
        exp_q.delete();
        reset = 1'b0;
        tick();
        checkOutput("post_rst_ready0", int'(s_ready), 0);
        tick();
        checkOutput("post_rst_ready1", int'(s_ready), 1);
        run_point(vecs[0], "post_rst");

        checkOutput("sb_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
